// File: rtl/axis_write_data_strb.sv
// axis_write_data_strb
//   AXI write-data channel engine. Narrow stream words are queued, packed
//   into AXI_DATA_WIDTH beats with per-byte strobes (streams may end
//   mid-beat), and split into bursts of burst_len+1 beats. Stream lengths
//   are queued through a small config FIFO.
//
//   Optional build macro: AXIS_WRITE_DATA_OVF_EN adds a sticky overflow
//   output that flags any push dropped because its FIFO was full.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   burst_len                beats per burst minus 1 (static while busy)
//   cfg_length/cfg_val       stream length push (in DATA_WIDTH words)
//   cfg_rdy                  config FIFO not full
//   data/valid               stream word push
//   ready                    data FIFO below half full (registered)
//   axi_wdata/wstrb/wlast    write beat
//   axi_wvalid/axi_wready    beat handshake
//   busy                     a stream is in progress
//   overflow                 (AXIS_WRITE_DATA_OVF_EN only) sticky drop flag
//
// State | meaning
//   CONFIG | idle, pop the next stream length when one is queued
//   SET    | load remaining-word counter from the popped length
//   ACTIVE | pop and pack stream words into beats
//   WAIT   | final beat formed, wait for its handshake
module axis_write_data_strb #(
  parameter int BUF_CFG_AWIDTH = 5,
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_LEN_WIDTH-1:0]    burst_len,
  input  logic [CFG_DWIDTH-1:0]       cfg_length,
  input  logic                        cfg_val,
  output logic                        cfg_rdy,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        busy
`ifdef AXIS_WRITE_DATA_OVF_EN
  ,
  output logic                        overflow
`endif
);

  localparam int RATIO  = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int BPW    = DATA_WIDTH / 8;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(RATIO + 1);
  localparam int DDEPTH = 2 ** BUF_AWIDTH;
  localparam int CDEPTH = 2 ** BUF_CFG_AWIDTH;
  localparam int DCNT_W = BUF_AWIDTH + 1;
  localparam int CCNT_W = BUF_CFG_AWIDTH + 1;

  localparam logic [CNT_W-1:0]  RATIO_C = CNT_W'(RATIO);
  localparam logic [DCNT_W-1:0] D_FULL  = DCNT_W'(DDEPTH);
  localparam logic [DCNT_W-1:0] D_HALF  = DCNT_W'(DDEPTH / 2);
  localparam logic [CCNT_W-1:0] C_FULL  = CCNT_W'(CDEPTH);

  localparam logic [3:0] S_CONFIG = 4'b0001;
  localparam logic [3:0] S_SET    = 4'b0010;
  localparam logic [3:0] S_ACTIVE = 4'b0100;
  localparam logic [3:0] S_WAIT   = 4'b1000;

  // Reset assertion is asynchronous everywhere; release is retimed by this
  // flop so pushes are only accepted from the first edge after release.
  logic rst_ok;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_ok <= 1'b0;
    else      rst_ok <= 1'b1;
  end

  // ---------------- config FIFO ----------------
  logic [CFG_DWIDTH-1:0]     cmem [CDEPTH];
  logic [BUF_CFG_AWIDTH-1:0] c_wp, c_rp;
  logic [CCNT_W-1:0]         c_cnt;
  logic                      c_full, c_empty, c_push, c_pop;

  logic [3:0] state;

  assign c_full  = (c_cnt == C_FULL);
  assign c_empty = (c_cnt == '0);
  assign c_push  = cfg_val & rst_ok & ~c_full;
  assign c_pop   = (state == S_CONFIG) & ~c_empty;
  assign cfg_rdy = rst_ok & ~c_full;

  always_ff @(posedge clk) begin
    if (c_push) cmem[c_wp] <= cfg_length;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_wp  <= '0;
      c_rp  <= '0;
      c_cnt <= '0;
    end else begin
      if (c_push) c_wp <= c_wp + 1'b1;
      if (c_pop)  c_rp <= c_rp + 1'b1;
      c_cnt <= c_cnt + CCNT_W'(c_push) - CCNT_W'(c_pop);
    end
  end

  // ---------------- data FIFO ----------------
  logic [DATA_WIDTH-1:0] dmem [DDEPTH];
  logic [BUF_AWIDTH-1:0] d_wp, d_rp;
  logic [DCNT_W-1:0]     d_cnt;
  logic                  d_full, d_push;
  logic [CNT_W-1:0]      take;

  assign d_full = (d_cnt == D_FULL);
  assign d_push = valid & rst_ok & ~d_full;

  always_ff @(posedge clk) begin
    if (d_push) dmem[d_wp] <= data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_wp  <= '0;
      d_rp  <= '0;
      d_cnt <= '0;
      ready <= 1'b0;
    end else begin
      if (d_push) d_wp <= d_wp + 1'b1;
      d_rp  <= d_rp + BUF_AWIDTH'(take);
      d_cnt <= d_cnt + DCNT_W'(d_push) - DCNT_W'(take);
      ready <= (d_cnt < D_HALF);
    end
  end

`ifdef AXIS_WRITE_DATA_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       overflow <= 1'b0;
    else if ((valid & d_full) | (cfg_val & c_full)) overflow <= 1'b1;
  end
`endif

  // ---------------- packer ----------------
  logic [CFG_DWIDTH-1:0]     cfg_q;
  logic [CFG_DWIDTH-1:0]     rem;
  logic [CNT_W-1:0]          lane, room, need, take_max;
  logic [AXI_DATA_WIDTH-1:0] acc_data, new_data;
  logic [STRB_W-1:0]         acc_strb, new_strb;
  logic                      completes, ob_space, beat_push, beat_fin;

  logic [1:0][AXI_DATA_WIDTH-1:0] ob_data, ob_data_n;
  logic [1:0][STRB_W-1:0]         ob_strb, ob_strb_n;
  logic [1:0]                     ob_fin, ob_fin_n;
  logic [1:0]                     ob_cnt, ob_cnt_n;
  logic                           pop_out;
  logic [AXI_LEN_WIDTH-1:0]       beat_cnt;

  assign axi_wvalid = (ob_cnt != 2'd0);
  assign pop_out    = axi_wvalid & axi_wready;
  assign ob_space   = (ob_cnt != 2'd2) | pop_out;

  // Words needed to close the current beat: the rest of the lanes, or the
  // rest of the stream if that is shorter. Words are taken in bulk so a
  // full FIFO sustains one beat per clock.
  always_comb begin
    room      = RATIO_C - lane;
    need      = (rem < CFG_DWIDTH'(room)) ? rem[CNT_W-1:0] : room;
    take_max  = (d_cnt < DCNT_W'(need)) ? d_cnt[CNT_W-1:0] : need;
    completes = (state == S_ACTIVE) && (need != '0) && (take_max == need);
    beat_fin  = (rem == CFG_DWIDTH'(need));
    take      = '0;
    if (state == S_ACTIVE) take = (completes && !ob_space) ? '0 : take_max;
    beat_push = completes && ob_space;
    new_data  = acc_data;
    new_strb  = acc_strb;
    for (int i = 0; i < RATIO; i++) begin
      if ((CNT_W'(i) >= lane) && (CNT_W'(i) < lane + take)) begin
        new_data[i*DATA_WIDTH +: DATA_WIDTH] = dmem[d_rp + BUF_AWIDTH'(CNT_W'(i) - lane)];
        new_strb[i*BPW +: BPW]               = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_CONFIG;
      cfg_q    <= '0;
      rem      <= '0;
      lane     <= '0;
      acc_data <= '0;
      acc_strb <= '0;
    end else begin
      case (state)
        S_CONFIG: begin
          if (!c_empty) begin
            cfg_q <= cmem[c_rp];
            state <= S_SET;
          end
        end
        S_SET: begin
          rem      <= cfg_q;
          lane     <= '0;
          acc_data <= '0;
          acc_strb <= '0;
          state    <= (cfg_q == '0) ? S_CONFIG : S_ACTIVE;
        end
        S_ACTIVE: begin
          if (take != '0) begin
            rem <= rem - CFG_DWIDTH'(take);
            if (beat_push) begin
              lane     <= '0;
              acc_data <= '0;
              acc_strb <= '0;
              if (beat_fin) state <= S_WAIT;
            end else begin
              lane     <= lane + take;
              acc_data <= new_data;
              acc_strb <= new_strb;
            end
          end
        end
        S_WAIT: begin
          if (pop_out && ob_fin[0]) state <= S_CONFIG;
        end
        default: state <= S_CONFIG;
      endcase
    end
  end

  assign busy = (state != S_CONFIG);

  // ---------------- 2-entry output register ----------------
  always_comb begin
    ob_data_n = ob_data;
    ob_strb_n = ob_strb;
    ob_fin_n  = ob_fin;
    ob_cnt_n  = ob_cnt;
    if (pop_out) begin
      ob_data_n[0] = ob_data[1];
      ob_strb_n[0] = ob_strb[1];
      ob_fin_n[0]  = ob_fin[1];
      ob_data_n[1] = '0;
      ob_strb_n[1] = '0;
      ob_fin_n[1]  = 1'b0;
      ob_cnt_n     = ob_cnt - 2'd1;
    end
    if (beat_push) begin
      if (ob_cnt_n == 2'd0) begin
        ob_data_n[0] = new_data;
        ob_strb_n[0] = new_strb;
        ob_fin_n[0]  = beat_fin;
      end else begin
        ob_data_n[1] = new_data;
        ob_strb_n[1] = new_strb;
        ob_fin_n[1]  = beat_fin;
      end
      ob_cnt_n = ob_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_data <= '0;
      ob_strb <= '0;
      ob_fin  <= '0;
      ob_cnt  <= '0;
    end else begin
      ob_data <= ob_data_n;
      ob_strb <= ob_strb_n;
      ob_fin  <= ob_fin_n;
      ob_cnt  <= ob_cnt_n;
    end
  end

  // Burst position counts accepted beats; any wlast handshake restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 beat_cnt <= '0;
    else if (pop_out)         beat_cnt <= axi_wlast ? '0 : beat_cnt + 1'b1;
    else if (state == S_SET)  beat_cnt <= '0;
  end

  assign axi_wdata = ob_data[0];
  assign axi_wstrb = ob_strb[0];
  assign axi_wlast = axi_wvalid & (ob_fin[0] | (beat_cnt == burst_len));

endmodule
